// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, FSM states,
// datapath mux encodings and the control word driven by mc_ctrl_outdec.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_BRANCH = 4'd8,
        ST_IEXEC  = 4'd9,
        ST_IWB    = 4'd10,
        ST_JUMP   = 4'd11,
        ST_JAL    = 4'd12
    } state_e;

    typedef enum logic [3:0] {
        OPC_R,
        OPC_J,
        OPC_JAL,
        OPC_BEQ,
        OPC_ADDI,
        OPC_SLTI,
        OPC_LW,
        OPC_SW,
        OPC_ILLEGAL
    } opclass_e;

    typedef enum logic [2:0] {
        ALU_FUNCT = 3'b000,
        ALU_ADD   = 3'b010,
        ALU_SUB   = 3'b110,
        ALU_SLT   = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        REGDST_RT = 2'b00,
        REGDST_RD = 2'b01,
        REGDST_RA = 2'b10
    } reg_dst_e;

    typedef enum logic [1:0] {
        M2R_ALUOUT = 2'b00,
        M2R_MDR    = 2'b01,
        M2R_PC     = 2'b10
    } mem_to_reg_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef struct packed {
        logic        pc_write;
        logic        pc_write_cond;
        pc_src_e     pc_src;
        logic        i_or_d;
        logic        mem_read;
        logic        mem_write;
        logic        ir_write;
        reg_dst_e    reg_dst;
        mem_to_reg_e mem_to_reg;
        logic        reg_write;
        logic        alu_src_a;
        alu_src_b_e  alu_src_b;
        alu_op_e     alu_op;
        logic        illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational output decoder: current state plus opcode to control word,
// and opcode classification shared with the next-state logic.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  state_e          i_state,
    input  logic [OP_W-1:0] i_op,
    output ctrl_t           o_ctl,
    output opclass_e        o_opc
);

    opclass_e w_opc;
    ctrl_t    w_ctl;

    always_comb begin
        w_opc = OPC_ILLEGAL;
        case (i_op)
            OP_W'(OP_RTYPE): w_opc = OPC_R;
            OP_W'(OP_J):     w_opc = OPC_J;
            OP_W'(OP_JAL):   w_opc = OPC_JAL;
            OP_W'(OP_BEQ):   w_opc = OPC_BEQ;
            OP_W'(OP_ADDI):  w_opc = OPC_ADDI;
            OP_W'(OP_SLTI):  w_opc = OPC_SLTI;
            OP_W'(OP_LW):    w_opc = OPC_LW;
            OP_W'(OP_SW):    w_opc = OPC_SW;
            default:         w_opc = OPC_ILLEGAL;
        endcase
    end

    always_comb begin
        w_ctl = '0;
        case (i_state)
            ST_FETCH: begin
                w_ctl.mem_read  = 1'b1;
                w_ctl.ir_write  = 1'b1;
                w_ctl.pc_write  = 1'b1;
                w_ctl.alu_src_b = SRCB_FOUR;
                w_ctl.alu_op    = ALU_ADD;
            end
            // ALU idle otherwise, so it precomputes the branch target here
            ST_DECODE: begin
                w_ctl.alu_src_b = SRCB_IMM_SH2;
                w_ctl.alu_op    = ALU_ADD;
                w_ctl.illegal   = (w_opc == OPC_ILLEGAL);
            end
            ST_MEMADR: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_IMM;
                w_ctl.alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                w_ctl.mem_read = 1'b1;
                w_ctl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.reg_dst    = REGDST_RT;
                w_ctl.mem_to_reg = M2R_MDR;
            end
            ST_MEMWR: begin
                w_ctl.mem_write = 1'b1;
                w_ctl.i_or_d    = 1'b1;
            end
            ST_EXEC: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_REG;
                w_ctl.alu_op    = ALU_FUNCT;
            end
            ST_RWB: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.reg_dst    = REGDST_RD;
                w_ctl.mem_to_reg = M2R_ALUOUT;
            end
            ST_BRANCH: begin
                w_ctl.alu_src_a     = 1'b1;
                w_ctl.alu_src_b     = SRCB_REG;
                w_ctl.alu_op        = ALU_SUB;
                w_ctl.pc_write_cond = 1'b1;
                w_ctl.pc_src        = PCSRC_ALUOUT;
            end
            ST_IEXEC: begin
                w_ctl.alu_src_a = 1'b1;
                w_ctl.alu_src_b = SRCB_IMM;
                w_ctl.alu_op    = (w_opc == OPC_SLTI) ? ALU_SLT : ALU_ADD;
            end
            ST_IWB: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.reg_dst    = REGDST_RT;
                w_ctl.mem_to_reg = M2R_ALUOUT;
            end
            ST_JUMP: begin
                w_ctl.pc_write = 1'b1;
                w_ctl.pc_src   = PCSRC_JUMP;
            end
            // PC already holds PC+4 from FETCH, which is the link value
            ST_JAL: begin
                w_ctl.pc_write   = 1'b1;
                w_ctl.pc_src     = PCSRC_JUMP;
                w_ctl.reg_write  = 1'b1;
                w_ctl.reg_dst    = REGDST_RA;
                w_ctl.mem_to_reg = M2R_PC;
            end
            default: w_ctl = '0;
        endcase
    end

    assign o_ctl = w_ctl;
    assign o_opc = w_opc;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state logic, memory wait gating.
// Define MCTRL_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR until mem_ready_i is high.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic [1:0]         pc_src_o,
    output logic               i_or_d_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               ir_write_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic               reg_write_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               illegal_o,
    output logic [3:0]         state_o
);

    state_e   r_state;
    state_e   w_next;
    ctrl_t    w_dec;
    ctrl_t    w_ctl;
    opclass_e w_opc;
    logic     w_mem_done;

`ifdef MCTRL_MEM_WAIT_EN
    assign w_mem_done = mem_ready_i;
`else
    logic w_unused_ready;
    assign w_unused_ready = mem_ready_i;
    assign w_mem_done     = 1'b1;
`endif

    mc_ctrl_outdec #(
        .OP_W(OP_W)
    ) u_outdec (
        .i_state(r_state),
        .i_op   (instr_op_i),
        .o_ctl  (w_dec),
        .o_opc  (w_opc)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  w_next = w_mem_done ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (w_opc)
                    OPC_LW, OPC_SW:     w_next = ST_MEMADR;
                    OPC_R:              w_next = ST_EXEC;
                    OPC_BEQ:            w_next = ST_BRANCH;
                    OPC_ADDI, OPC_SLTI: w_next = ST_IEXEC;
                    OPC_J:              w_next = ST_JUMP;
                    OPC_JAL:            w_next = ST_JAL;
                    default:            w_next = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                case (w_opc)
                    OPC_LW:  w_next = ST_MEMRD;
                    OPC_SW:  w_next = ST_MEMWR;
                    default: w_next = ST_FETCH;
                endcase
            end
            ST_MEMRD:  w_next = w_mem_done ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  w_next = w_mem_done ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   w_next = ST_RWB;
            ST_IEXEC: begin
                case (w_opc)
                    OPC_ADDI, OPC_SLTI: w_next = ST_IWB;
                    default:            w_next = ST_FETCH;
                endcase
            end
            default:   w_next = ST_FETCH;
        endcase
    end

    // Outputs are masked combinationally by rst_n so no strobe leaks while in reset
    always_comb begin
        w_ctl = w_dec;
`ifdef MCTRL_MEM_WAIT_EN
        if ((r_state == ST_FETCH) && !mem_ready_i) begin
            w_ctl.ir_write = 1'b0;
            w_ctl.pc_write = 1'b0;
        end
`endif
        if (!rst_n) begin
            w_ctl = '0;
        end
    end

    assign pc_write_o      = w_ctl.pc_write;
    assign pc_write_cond_o = w_ctl.pc_write_cond;
    assign pc_src_o        = w_ctl.pc_src;
    assign i_or_d_o        = w_ctl.i_or_d;
    assign mem_read_o      = w_ctl.mem_read;
    assign mem_write_o     = w_ctl.mem_write;
    assign ir_write_o      = w_ctl.ir_write;
    assign reg_dst_o       = w_ctl.reg_dst;
    assign mem_to_reg_o    = w_ctl.mem_to_reg;
    assign reg_write_o     = w_ctl.reg_write;
    assign alu_src_a_o     = w_ctl.alu_src_a;
    assign alu_src_b_o     = w_ctl.alu_src_b;
    assign alu_op_o        = ALUOP_W'(w_ctl.alu_op);
    assign illegal_o       = w_ctl.illegal;
    assign state_o         = rst_n ? r_state : 4'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random
// instruction streams checked every cycle against an instruction-timeline model.
module tb_multicycle_ctrl;

    localparam int OP_W    = 6;
    localparam int ALUOP_W = 3;

    logic               clk_i = 1'b0;
    logic               rst_n;
    logic [OP_W-1:0]    instr_op_i;
    logic               mem_ready_i;
    logic               pc_write_o;
    logic               pc_write_cond_o;
    logic [1:0]         pc_src_o;
    logic               i_or_d_o;
    logic               mem_read_o;
    logic               mem_write_o;
    logic               ir_write_o;
    logic [1:0]         reg_dst_o;
    logic [1:0]         mem_to_reg_o;
    logic               reg_write_o;
    logic               alu_src_a_o;
    logic [1:0]         alu_src_b_o;
    logic [ALUOP_W-1:0] alu_op_o;
    logic               illegal_o;
    logic [3:0]         state_o;

    multicycle_ctrl #(
        .OP_W   (OP_W),
        .ALUOP_W(ALUOP_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .instr_op_i     (instr_op_i),
        .mem_ready_i    (mem_ready_i),
        .pc_write_o     (pc_write_o),
        .pc_write_cond_o(pc_write_cond_o),
        .pc_src_o       (pc_src_o),
        .i_or_d_o       (i_or_d_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .ir_write_o     (ir_write_o),
        .reg_dst_o      (reg_dst_o),
        .mem_to_reg_o   (mem_to_reg_o),
        .reg_write_o    (reg_write_o),
        .alu_src_a_o    (alu_src_a_o),
        .alu_src_b_o    (alu_src_b_o),
        .alu_op_o       (alu_op_o),
        .illegal_o      (illegal_o),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcs;
        logic       iod;
        logic       mr;
        logic       mw;
        logic       irw;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       rw;
        logic       sa;
        logic [1:0] sb;
        logic [2:0] aop;
        logic       ill;
        logic [3:0] st;
    } obs_t;

    int         n_chk = 0;
    int         n_fail = 0;
    int         m_k = 0;      // cycle index within the current instruction
    logic [5:0] m_op = 6'd0;  // opcode the model is sequencing

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd8, 6'd10, 6'd35, 6'd43};
    endfunction

    function automatic int n_cycles(input logic [5:0] op);
        case (op)
            6'd35:                     return 5;
            6'd43, 6'd0, 6'd8, 6'd10:  return 4;
            6'd4, 6'd2, 6'd3:          return 3;
            default:                   return 2;
        endcase
    endfunction

    // Cycle 0 is the instruction fetch; cycle 3 of lw/sw is the data access.
    function automatic logic is_mem_cycle(input logic [5:0] op, input int k);
        return (k == 0) || (k == 3 && (op == 6'd35 || op == 6'd43));
    endfunction

    function automatic obs_t exp_at(input logic [5:0] op, input int k, input logic rdy);
        obs_t e;
        e = '0;
        if (k == 0) begin
            e.mr = 1'b1; e.irw = rdy; e.pcw = rdy; e.sb = 2'b01; e.aop = 3'b010; e.st = 4'd0;
        end else if (k == 1) begin
            e.sb = 2'b11; e.aop = 3'b010; e.ill = !legal(op); e.st = 4'd1;
        end else begin
            case (op)
                6'd35, 6'd43: begin
                    if (k == 2) begin
                        e.sa = 1'b1; e.sb = 2'b10; e.aop = 3'b010; e.st = 4'd2;
                    end else if (op == 6'd35 && k == 3) begin
                        e.mr = 1'b1; e.iod = 1'b1; e.st = 4'd3;
                    end else if (op == 6'd35) begin
                        e.rw = 1'b1; e.rdst = 2'b00; e.m2r = 2'b01; e.st = 4'd4;
                    end else begin
                        e.mw = 1'b1; e.iod = 1'b1; e.st = 4'd5;
                    end
                end
                6'd0: begin
                    if (k == 2) begin
                        e.sa = 1'b1; e.sb = 2'b00; e.aop = 3'b000; e.st = 4'd6;
                    end else begin
                        e.rw = 1'b1; e.rdst = 2'b01; e.m2r = 2'b00; e.st = 4'd7;
                    end
                end
                6'd8, 6'd10: begin
                    if (k == 2) begin
                        e.sa = 1'b1; e.sb = 2'b10; e.aop = (op == 6'd10) ? 3'b111 : 3'b010; e.st = 4'd9;
                    end else begin
                        e.rw = 1'b1; e.rdst = 2'b00; e.m2r = 2'b00; e.st = 4'd10;
                    end
                end
                6'd4: begin
                    e.sa = 1'b1; e.sb = 2'b00; e.aop = 3'b110; e.pcwc = 1'b1; e.pcs = 2'b01; e.st = 4'd8;
                end
                6'd2: begin
                    e.pcw = 1'b1; e.pcs = 2'b10; e.st = 4'd11;
                end
                6'd3: begin
                    e.pcw = 1'b1; e.pcs = 2'b10; e.rw = 1'b1; e.rdst = 2'b10; e.m2r = 2'b10; e.st = 4'd12;
                end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    function automatic obs_t sample();
        return {pc_write_o, pc_write_cond_o, pc_src_o, i_or_d_o, mem_read_o, mem_write_o,
                ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
                alu_op_o, illegal_o, state_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #2;
    endtask

    // Model-based compare on every falling edge
    initial begin : compare
        logic rdy;
        obs_t act;
        obs_t expv;
        forever begin
            @(negedge clk_i);
`ifdef MCTRL_MEM_WAIT_EN
            rdy = mem_ready_i;
`else
            rdy = 1'b1;
`endif
            if (m_k == 1) m_op = instr_op_i;
            expv = rst_n ? exp_at(m_op, m_k, rdy) : '0;
            act  = sample();
            n_chk++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t k=%0d op=%0d: got %h expected %h",
                         $time, m_k, m_op, act, expv);
            end
            if (!rst_n) begin
                m_k = 0;
            end else if (!(is_mem_cycle(m_op, m_k) && !rdy)) begin
                m_k++;
                if (m_k >= n_cycles(m_op)) m_k = 0;
            end
        end
    end

    initial begin : stim
        logic [5:0] legal_ops [8];
        int  cyc;
        int  mw;
        bit  done;
        legal_ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd8, 6'd10, 6'd35, 6'd43};

        rst_n       = 1'b0;
        instr_op_i  = 6'd35;
        mem_ready_i = 1'b1;
        repeat (2) nxt();
        #2;
        chk("reset_outputs", 32'(sample()), 32'd0);
        chk("reset_state", 32'(state_o), 32'd0);

        // lw: 5 cycles
        nxt(); rst_n = 1'b1; #2;
        chk("lw_fetch_state", 32'(state_o), 32'd0);
        chk("lw_fetch_memread", 32'(mem_read_o), 32'd1);
        chk("lw_fetch_irwrite", 32'(ir_write_o), 32'd1);
        chk("lw_fetch_pcwrite", 32'(pc_write_o), 32'd1);
        nxt(); #2;
        chk("lw_decode_state", 32'(state_o), 32'd1);
        chk("lw_decode_srcb", 32'(alu_src_b_o), 32'd3);
        nxt(); #2;
        chk("lw_memadr_srcb", 32'(alu_src_b_o), 32'd2);
        chk("lw_memadr_aluop", 32'(alu_op_o), 32'd2);
        nxt(); #2;
        chk("lw_memrd_iord", 32'(i_or_d_o), 32'd1);
        chk("lw_memrd_state", 32'(state_o), 32'd3);
        nxt(); #2;
        chk("lw_memwb_regwrite", 32'(reg_write_o), 32'd1);
        chk("lw_memwb_m2r", 32'(mem_to_reg_o), 32'd1);
        nxt(); #2;
        chk("lw_back_fetch", 32'(state_o), 32'd0);

        // jal: 3 cycles
        instr_op_i = 6'd3;
        nxt(); nxt(); #2;
        chk("jal_pcwrite", 32'(pc_write_o), 32'd1);
        chk("jal_pcsrc", 32'(pc_src_o), 32'd2);
        chk("jal_regwrite", 32'(reg_write_o), 32'd1);
        chk("jal_regdst", 32'(reg_dst_o), 32'd2);
        chk("jal_m2r", 32'(mem_to_reg_o), 32'd2);
        nxt(); #2;
        chk("jal_back_fetch", 32'(state_o), 32'd0);

        // slti
        instr_op_i = 6'd10;
        nxt(); nxt(); #2;
        chk("slti_iexec_aluop", 32'(alu_op_o), 32'd7);
        chk("slti_iexec_state", 32'(state_o), 32'd9);
        nxt(); #2;
        chk("slti_iwb_regdst", 32'(reg_dst_o), 32'd0);
        chk("slti_iwb_regwrite", 32'(reg_write_o), 32'd1);
        nxt(); #2;
        chk("slti_back_fetch", 32'(state_o), 32'd0);

        // beq: 3 cycles
        instr_op_i = 6'd4;
        nxt(); nxt(); #2;
        chk("beq_aluop", 32'(alu_op_o), 32'd6);
        chk("beq_pcwcond", 32'(pc_write_cond_o), 32'd1);
        nxt(); #2;
        chk("beq_back_fetch", 32'(state_o), 32'd0);

        // illegal opcode: 2 cycles
        instr_op_i = 6'd63;
        nxt(); #2;
        chk("ill_flag", 32'(illegal_o), 32'd1);
        chk("ill_state", 32'(state_o), 32'd1);
        chk("ill_no_writes", 32'({reg_write_o, mem_write_o, pc_write_o, pc_write_cond_o, ir_write_o}), 32'd0);
        nxt(); #2;
        chk("ill_back_fetch", 32'(state_o), 32'd0);
        chk("ill_one_cycle", 32'(illegal_o), 32'd0);

        // reset during MEMRD of lw
        instr_op_i = 6'd35;
        nxt(); nxt(); nxt(); #2;
        chk("rstmid_in_memrd", 32'(state_o), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rstmid_outputs_zero", 32'(sample()), 32'd0);
        nxt(); rst_n = 1'b1; #2;
        chk("rstmid_state_fetch", 32'(state_o), 32'd0);
        chk("rstmid_no_memwb", 32'(reg_write_o), 32'd0);

        // sw with memory not ready for two cycles in the store cycle
        instr_op_i = 6'd43;
        cyc  = 1;
        mw   = 0;
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            nxt();
            mem_ready_i = !((cyc + 1 == 4) || (cyc + 1 == 5));
            #2;
            if (state_o == 4'd0) done = 1'b1;
            else begin
                cyc++;
                if (mem_write_o) mw++;
            end
        end
        mem_ready_i = 1'b1;
`ifdef MCTRL_MEM_WAIT_EN
        chk("sw_wait_cycles", 32'(cyc), 32'd6);
        chk("sw_wait_memwrite", 32'(mw), 32'd3);
`else
        chk("sw_wait_cycles", 32'(cyc), 32'd4);
        chk("sw_wait_memwrite", 32'(mw), 32'd1);
`endif

        // random instruction stream with occasional resets and memory stalls
        repeat (3000) begin
            nxt();
            rst_n       = ($urandom_range(0, 79) != 0);
            mem_ready_i = ($urandom_range(0, 3) != 0);
            if (m_k == 0) begin
                if ($urandom_range(0, 9) < 8) instr_op_i = legal_ops[$urandom_range(0, 7)];
                else                          instr_op_i = 6'($urandom_range(0, 63));
            end
        end
        rst_n = 1'b1;
        mem_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
